// File: rtl/param_register_file.sv
// param_register_file
//   Parametrised datapath register file sitting between the writeback mux and
//   the ALU operand inputs. Two combinational read ports, one write port,
//   optional hardwired zero register, optional write-to-read bypass, a
//   per-register pending scoreboard for multi-cycle producers and a
//   sequential clear-sweep engine.
//
// Ports
//   clk, rst_n                  clock (posedge) / async active-low reset
//   RF_W_en, WriteAddress,
//   WriteData                   write port
//   ReadAddrA/B, DataOutputA/B  combinational read ports
//   Reserve_en, ReserveAddr     mark a register's result as outstanding
//   PendingA/B                  registered pending bit of each read address
//   Clear_req, Busy             start a clear sweep / sweep in progress
//
// FSM states
//   state | meaning
//   IDLE  | normal operation, writes and reserves accepted
//   SWEEP | clearing regs[counter] each cycle, writes/reserves dropped
module param_register_file #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RF_W_en,
  input  logic [ADDR_W-1:0] WriteAddress,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadAddrA,
  input  logic [ADDR_W-1:0] ReadAddrB,
  output logic [DATA_W-1:0] DataOutputA,
  output logic [DATA_W-1:0] DataOutputB,
  input  logic              Reserve_en,
  input  logic [ADDR_W-1:0] ReserveAddr,
  output logic              PendingA,
  output logic              PendingB,
  input  logic              Clear_req,
  output logic              Busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] counter, counter_next;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;

  logic idle;
  logic wr_ok;
  logic rsv_ok;

  assign idle   = (state == IDLE);
  // Register 0 is read-only when hardwired to zero, so it can neither be
  // written nor reserved.
  assign wr_ok  = RF_W_en && idle && !((ZERO_REG != 0) && (WriteAddress == '0));
  assign rsv_ok = Reserve_en && idle && !((ZERO_REG != 0) && (ReserveAddr == '0));
  assign Busy   = (state == SWEEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  // The counter wraps from DEPTH-1 to 0 on the same edge the FSM returns to
  // IDLE, so it is already zero for the next sweep.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    case (state)
      IDLE: begin
        if (Clear_req) begin
          state_next   = SWEEP;
          counter_next = '0;
        end
      end
      SWEEP: begin
        counter_next = counter + 1'b1;
        if (counter == ADDR_W'(DEPTH - 1)) state_next = IDLE;
      end
      default: begin
        state_next   = IDLE;
        counter_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == SWEEP) begin
      regs[counter] <= '0;
    end else if (wr_ok) begin
      regs[WriteAddress] <= WriteData;
    end
  end

  // Reserve is applied after the write clear so that a same-edge reserve and
  // write of one address leaves the register pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (idle) begin
      if (Clear_req) begin
        pending <= '0;
      end else begin
        if (wr_ok)  pending[WriteAddress] <= 1'b0;
        if (rsv_ok) pending[ReserveAddr]  <= 1'b1;
      end
    end
  end

  always_comb begin
    DataOutputA = regs[ReadAddrA];
    if ((ZERO_REG != 0) && (ReadAddrA == '0)) DataOutputA = '0;
    if ((BYPASS != 0) && wr_ok && (ReadAddrA == WriteAddress)) DataOutputA = WriteData;
  end

  always_comb begin
    DataOutputB = regs[ReadAddrB];
    if ((ZERO_REG != 0) && (ReadAddrB == '0)) DataOutputB = '0;
    if ((BYPASS != 0) && wr_ok && (ReadAddrB == WriteAddress)) DataOutputB = WriteData;
  end

  assign PendingA = pending[ReadAddrA];
  assign PendingB = pending[ReadAddrB];

endmodule
